// File: rtl/nios_system_com_nios_oci_trace_pkg.sv
// Shared definitions for the OCI trace monitor: state encoding and the
// default-geometry frame layout (count above packed slot buffer).
package nios_system_com_nios_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_SLOT_W  = 2;
    localparam int DEF_SLOTS   = 15;
    localparam int DEF_COUNT_W = 4;

    typedef struct packed {
        logic [DEF_COUNT_W-1:0]          count;
        logic [DEF_SLOTS*DEF_SLOT_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/nios_system_com_nios_oci_trace_fifo.sv
// Synchronous frame FIFO with a show-ahead head word; a push is allowed on a
// full FIFO when a pop happens in the same cycle.
module nios_system_com_nios_oci_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers expose them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/nios_system_com_nios_oci_trace_monitor.sv
// OCI trace sink: qualifies and clamps packed trace frames, buffers them,
// streams them out and keeps saturating statistics plus an end-of-test drain.
module nios_system_com_nios_oci_trace_monitor
    import nios_system_com_nios_oci_trace_pkg::*;
#(
    parameter int SLOT_W  = 2,
    parameter int SLOTS   = 15,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 8,
    parameter int STAT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dct_valid,
    input  logic [SLOTS*SLOT_W-1:0]   dct_buffer,
    input  logic [COUNT_W-1:0]        dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLOTS*SLOT_W-1:0]   out_data,
    output logic [COUNT_W-1:0]        out_count,
    output logic [STAT_W-1:0]         frame_cnt,
    output logic [STAT_W-1:0]         slot_cnt,
    output logic [STAT_W-1:0]         drop_cnt,
    output logic                      overflow,
    output logic                      count_err,
    output logic [1:0]                state,
    output logic                      done
);
    localparam int BUF_W = SLOTS * SLOT_W;
    localparam logic [COUNT_W-1:0] SLOTS_C  = COUNT_W'(SLOTS);
    localparam logic [STAT_W-1:0]  STAT_MAX = '1;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [BUF_W-1:0]   data;
    } mon_frame_t;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [STAT_W-1:0]  r_frame_cnt;
    logic [STAT_W-1:0]  r_slot_cnt;
    logic [STAT_W-1:0]  r_drop_cnt;
    logic               r_overflow;
    logic               r_count_err;
    logic               r_done;
    logic               w_present;
    logic               w_count_bad;
    logic [COUNT_W-1:0] w_count_clamped;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_write;
    logic               w_drop;
    logic               w_run_drop;
    logic [STAT_W:0]    w_slot_sum;
    mon_frame_t         w_in_frame;
    mon_frame_t         w_head_frame;

    assign w_present       = dct_valid && (dct_count != '0);
    assign w_count_bad     = (dct_count > SLOTS_C);
    assign w_count_clamped = w_count_bad ? SLOTS_C : dct_count;
    assign w_in_frame      = '{count: w_count_clamped, data: dct_buffer};

    assign w_pop      = out_ready && !w_empty;
    assign w_write    = w_present && (r_state == ST_RUN) && (!w_full || w_pop);
    assign w_run_drop = w_present && (r_state == ST_RUN) && !w_write;
    assign w_drop     = w_run_drop || (w_present && (r_state == ST_DRAIN));
    // One extra bit catches the carry that marks slot_cnt saturation.
    assign w_slot_sum = {1'b0, r_slot_cnt} + (STAT_W+1)'(w_count_clamped);

    nios_system_com_nios_oci_trace_fifo #(
        .WIDTH ($bits(mon_frame_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_write),
        .i_data  (w_in_frame),
        .i_pop   (out_ready),
        .o_data  (w_head_frame),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_head_frame.data;
    assign out_count = w_head_frame.count;
    assign frame_cnt = r_frame_cnt;
    assign slot_cnt  = r_slot_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;
    assign count_err = r_count_err;
    assign state     = r_state;
    assign done      = r_done;

    // Next-state logic; DONE is absorbing until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (test_ending || test_has_ended) w_state_nxt = ST_DRAIN;
                else                               w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (w_empty && test_has_ended) w_state_nxt = ST_DONE;
                else                           w_state_nxt = ST_DRAIN;
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State, saturating statistics and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_slot_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_count_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_write) begin
                if (r_frame_cnt != STAT_MAX) r_frame_cnt <= r_frame_cnt + STAT_W'(1);
                r_slot_cnt <= w_slot_sum[STAT_W] ? STAT_MAX : w_slot_sum[STAT_W-1:0];
            end
            if (w_drop && (r_drop_cnt != STAT_MAX)) r_drop_cnt <= r_drop_cnt + STAT_W'(1);
            if (w_run_drop) r_overflow <= 1'b1;
            if (w_present && w_count_bad && (r_state != ST_DONE)) r_count_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios_system_com_nios_oci_trace_monitor.sv
// Scoreboard bench: directed frames push expected words, a negedge monitor
// pops and compares every frame the DUT hands over.
module tb_nios_system_com_nios_oci_trace_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, dct_valid, test_ending, test_has_ended, out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid, overflow, count_err, done;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [31:0] frame_cnt, slot_cnt, drop_cnt;
    logic [1:0]  state;

    logic        tie0 = 1'b0;
    logic        tie1 = 1'b1;
    logic        b_valid, b_out_valid, b_ovf, b_cerr, b_done;
    logic [27:0] b_out_data;
    logic [3:0]  b_out_count;
    logic [31:0] b_frame, b_slot, b_drop;
    logic [1:0]  b_state;
    logic        c_valid, c_out_valid, c_ovf, c_cerr, c_done;
    logic [29:0] c_out_data;
    logic [3:0]  c_out_count;
    logic [3:0]  c_frame, c_slot, c_drop;
    logic [1:0]  c_state;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    nios_system_com_nios_oci_trace_monitor u_dut (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .frame_cnt(frame_cnt), .slot_cnt(slot_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
        .count_err(count_err), .state(state), .done(done));

    nios_system_com_nios_oci_trace_monitor #(.SLOTS(14)) u_dut14 (
        .clk(clk), .reset_n(reset_n), .dct_valid(b_valid), .dct_buffer(dct_buffer[27:0]),
        .dct_count(dct_count), .test_ending(tie0), .test_has_ended(tie0),
        .out_valid(b_out_valid), .out_ready(tie0), .out_data(b_out_data), .out_count(b_out_count),
        .frame_cnt(b_frame), .slot_cnt(b_slot), .drop_cnt(b_drop), .overflow(b_ovf),
        .count_err(b_cerr), .state(b_state), .done(b_done));

    nios_system_com_nios_oci_trace_monitor #(.STAT_W(4)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .dct_valid(c_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(tie0), .test_has_ended(tie0),
        .out_valid(c_out_valid), .out_ready(tie1), .out_data(c_out_data), .out_count(c_out_count),
        .frame_cnt(c_frame), .slot_cnt(c_slot), .drop_cnt(c_drop), .overflow(c_ovf),
        .count_err(c_cerr), .state(c_state), .done(c_done));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pat(input int i);
        pat = 30'(32'h02A5_1C3D ^ (i * 32'h0013_0107));
    endfunction

    // Scoreboard monitor: a handshake seen here completes at the next posedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got %0h expected none", {out_count, out_data});
            end else begin
                chk("pop_frame", {30'd0, out_count, out_data}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; dct_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b0;
        dct_buffer = 30'd0; dct_count = 4'd0;
        repeat (3) tick();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [29:0] d, input logic [3:0] c, input logic acc);
        dct_valid = 1'b1; dct_buffer = d; dct_count = c;
        if (acc) exp_q.push_back({c, d});
        tick();
        dct_valid = 1'b0;
    endtask

    logic [29:0] tmp;

    initial begin
        // Reset and streaming throughput
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 30'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_slot_cnt", slot_cnt, 32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);
        chk("rst_flags", {overflow, count_err, done}, 3'd0);
        chk("rst_state", state, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(pat(i), 4'd15, 1'b1);
            chk("latency_valid", out_valid, 1'b1);
            chk("latency_data", out_data, pat(i));
        end
        tick();
        chk("stream_frame_cnt", frame_cnt, 32'd10);
        chk("stream_slot_cnt", slot_cnt, 32'd150);
        chk("stream_drop_cnt", drop_cnt, 32'd0);
        chk("stream_sb_empty", exp_q.size(), 0);
        chk("stream_out_valid", out_valid, 1'b0);

        // Overflow and push-while-full-with-pop
        do_reset();
        for (int i = 0; i < 12; i++) send(pat(20 + i), 4'd1, (i < 8));
        chk("ovf_frame_cnt", frame_cnt, 32'd8);
        chk("ovf_drop_cnt", drop_cnt, 32'd4);
        chk("ovf_flag", overflow, 1'b1);
        out_ready = 1'b1;
        send(pat(40), 4'd1, 1'b1);
        chk("ovf_full_push_frame_cnt", frame_cnt, 32'd9);
        chk("ovf_full_push_drop_cnt", drop_cnt, 32'd4);
        repeat (10) tick();
        chk("ovf_sb_empty", exp_q.size(), 0);
        chk("ovf_out_valid", out_valid, 1'b0);

        // Count qualification and clamping
        do_reset();
        out_ready = 1'b1;
        send(pat(50), 4'd0, 1'b0);
        chk("cnt0_ignored_valid", out_valid, 1'b0);
        chk("cnt0_ignored_frames", frame_cnt, 32'd0);
        send(pat(51), 4'd3, 1'b1);
        send(pat(52), 4'd15, 1'b1);
        chk("cnt_slot_cnt", slot_cnt, 32'd18);
        chk("cnt_frame_cnt", frame_cnt, 32'd2);
        chk("cnt_no_err", count_err, 1'b0);
        tmp = pat(53);
        dct_buffer = tmp; dct_count = 4'd15; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("clamp_count_err", b_cerr, 1'b1);
        chk("clamp_out_count", b_out_count, 4'd14);
        chk("clamp_out_data", b_out_data, tmp[27:0]);
        chk("clamp_slot_cnt", b_slot, 32'd14);
        tick();
        chk("cnt_sb_empty", exp_q.size(), 0);

        // Drain sequence
        do_reset();
        for (int i = 0; i < 5; i++) send(pat(60 + i), 4'd2, 1'b1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("drain_enter", state, 2'd1);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        test_has_ended = 1'b1;
        send(pat(70), 4'd2, 1'b0);
        send(pat(71), 4'd2, 1'b0);
        chk("drain_drop_cnt", drop_cnt, 32'd2);
        chk("drain_no_overflow", overflow, 1'b0);
        chk("drain_wait_nonempty", state, 2'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_after_last_pop_state", state, 2'd1);
        chk("drain_after_last_pop_valid", out_valid, 1'b0);
        tick();
        chk("done_state", state, 2'd2);
        chk("done_flag", done, 1'b1);
        send(pat(72), 4'd2, 1'b0);
        tick();
        chk("done_frame_cnt", frame_cnt, 32'd5);
        chk("done_slot_cnt", slot_cnt, 32'd10);
        chk("done_drop_cnt", drop_cnt, 32'd2);
        chk("done_absorbing", state, 2'd2);
        chk("drain_sb_empty", exp_q.size(), 0);

        // Saturation on the narrow-counter instance
        do_reset();
        dct_buffer = pat(80); dct_count = 4'd3; c_valid = 1'b1;
        repeat (4) tick();
        chk("sat_mid_frame_cnt", c_frame, 4'd4);
        chk("sat_mid_slot_cnt", c_slot, 4'd12);
        repeat (16) tick();
        c_valid = 1'b0;
        chk("sat_frame_cnt", c_frame, 4'd15);
        chk("sat_slot_cnt", c_slot, 4'd15);
        chk("sat_drop_cnt", c_drop, 4'd0);

        // Reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 3; i++) send(pat(90 + i), 4'd4, 1'b1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("mid_drain_state", state, 2'd1);
        chk("mid_drain_nonempty", out_valid, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_state", state, 2'd0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_counters", {frame_cnt, slot_cnt, drop_cnt}, 96'd0);
        chk("mid_rst_flags", {overflow, count_err, done}, 3'd0);
        exp_q.delete();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_system_com_nios_oci_trace_monitor.md
# nios_system_com_nios_oci_trace_monitor

Parametrised, synthesizable successor to the OCI trace test-bench sink. It captures packed trace frames (slot buffer plus valid-slot count) from the Nios OCI trace packer and buffers them in a FIFO. It streams them out over a valid/ready port, keeps saturating statistics, and runs an end-of-test drain sequence driven by `test_ending` and `test_has_ended`.

## Interface
Parameters:
- `SLOT_W`, default 2: bits per trace slot.
- `SLOTS`, default 15: slots per frame; the buffer is SLOTS*SLOT_W bits (30 by default).
- `COUNT_W`, default 4: width of the slot count; must satisfy 2^COUNT_W > SLOTS.
- `DEPTH`, default 8: FIFO depth in frames; power of two, at least 2.
- `STAT_W`, default 32: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: reset, synchronous and active-low.
- `dct_valid`, in, 1: frame strobe.
- `dct_buffer`, in, SLOTS*SLOT_W: packed slots; slot 0 is in the LSBs.
- `dct_count`, in, COUNT_W: number of valid slots in the frame.
- `test_ending`, in, 1: request to stop capture and drain.
- `test_has_ended`, in, 1: the test is finished.
- `out_valid`, out, 1: a frame is available at the head of the FIFO.
- `out_ready`, in, 1: the consumer accepts the head frame.
- `out_data`, out, SLOTS*SLOT_W: head-frame slots.
- `out_count`, out, COUNT_W: head-frame slot count.
- `frame_cnt`, out, STAT_W: frames accepted into the FIFO.
- `slot_cnt`, out, STAT_W: sum of the accepted (clamped) counts.
- `drop_cnt`, out, STAT_W: frames lost.
- `overflow`, out, 1: sticky; set when a frame is dropped because the FIFO is full.
- `count_err`, out, 1: sticky; set when a frame arrives with dct_count > SLOTS.
- `state`, out, 2: current state (RUN=0, DRAIN=1, DONE=2).
- `done`, out, 1: high while in DONE.

## Operation
- **Reset.** Asserting `reset_n` low clears every output to 0 and empties the FIFO; `state` is RUN. Reset overrides any activity in the same cycle, including a reset asserted mid-drain.
- **Frame qualification.** A frame is presented when `dct_valid`=1 and `dct_count`≠0. A frame with count 0 is ignored and not counted.
- **Count clamping.** If `dct_count` > SLOTS, `count_err` is set and the stored count is clamped to SLOTS. The buffer bits are stored unchanged.
- **RUN state.**
  - A presented frame is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle (`out_valid` and `out_ready`).
  - Each write increments `frame_cnt` by 1 and adds the clamped count to `slot_cnt`.
  - A presented frame that cannot be written increments `drop_cnt` and sets `overflow`.
- **RUN → DRAIN** on `test_ending`=1. A frame presented in the same cycle as `test_ending` is still handled by RUN rules.
- **DRAIN state.**
  - No writes occur. Presented frames increment `drop_cnt` but do not set `overflow`.
  - Pops continue normally.
- **DRAIN → DONE** when the FIFO is empty and `test_has_ended`=1 in the same cycle. If `test_has_ended` arrives early, the block waits for the FIFO to empty.
- **DONE state.** The block is absorbing: only reset exits it. All counters freeze, presented frames are ignored, and `done`=1.
- **RUN with `test_has_ended` alone.** If `test_has_ended`=1 in RUN without `test_ending`, the block goes to DRAIN that cycle, so DONE is reached at the earliest one cycle later.
- **Saturation.** All counters saturate at 2^STAT_W−1 and never wrap. `slot_cnt` saturates when the addition would carry out.
- **FIFO pointers.** Pointers are log2(DEPTH)+1 bits; the extra bit distinguishes full from empty. Pointer wrap-around is modulo 2*DEPTH.

## Timing
- Write latency: a frame written at edge N appears on `out_valid`/`out_data` after edge N when the FIFO was empty. There is no combinational path from `dct_*` to `out_*`.
- `out_data` and `out_count` are stable and valid whenever `out_valid`=1. A pop occurs at the edge where `out_valid` and `out_ready` are both 1.
- `out_valid` may not drop without a pop.
- `out_ready` may be asserted while `out_valid`=0 with no effect.
- Statistics and sticky flags update at the same edge as the event that causes them.
- State transitions take effect at the edge following the qualifying inputs; `done` rises together with `state`=2.
- Full throughput: one write and one pop per cycle sustained, with no bubbles.

## Structure
- Shared package `nios_system_com_nios_oci_trace_pkg` holds:
  - the state encoding constants ST_RUN, ST_DRAIN, ST_DONE;
  - a frame typedef (data plus count) built from SLOT_W, SLOTS and COUNT_W.
- Sub-module `nios_system_com_nios_oci_trace_fifo`: a synchronous FIFO parameterised by width and DEPTH. It provides `full`/`empty` flags and read-first-word output registers, and supports simultaneous push and pop when full.
- The top level contains the state machine, qualification and clamping logic, saturating counters and sticky flags.

## Test plan
- **Reset.** Reset for 3 cycles, then 10 frames of count 15 with `out_ready`=1. Required: all 10 frames emerge in order one cycle after capture; `frame_cnt`=10, `slot_cnt`=150, `drop_cnt`=0.
- **Overflow.** With `out_ready`=0, send 12 frames (DEPTH=8). Required: 8 stored, `drop_cnt`=4, `overflow`=1. Then send a 13th frame while popping on a full FIFO; required: it is accepted and `frame_cnt`=9.
- **Count checking.** Send counts 0, 3 and 15 (COUNT_W=4, SLOTS=15), then push count 15 onto a SLOTS=14 configuration. Required: the count-0 frame is ignored; `slot_cnt`=18; on SLOTS=14, `count_err`=1 and `out_count`=14.
- **Drain.** Fill 5 frames, raise `test_ending`, then `test_has_ended` after 2 pops, and send frames during DRAIN. Required: those frames are dropped with `overflow` unchanged; DONE is entered only after the 5th pop; `done`=1; counters frozen.
- **Saturation.** With STAT_W=4, send 20 frames with `out_ready`=1. Required: `frame_cnt` sticks at 15 and `slot_cnt` sticks at 15.
- **Reset mid-drain.** Assert `reset_n`=0 during DRAIN with the FIFO non-empty. Required: the next cycle shows `state`=RUN, `out_valid`=0 and all counters 0.
